mips_mc_ctrl: RTL and testbench
===============================

MIPS_MC_CTRL -- requirements
Module: mips_mc_ctrl

Interface
REQ-001 Parameter WAIT_LIMIT, default 15, is the maximum number of cycles the FSM waits for mem_ready before aborting.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 op  input  6  instruction opcode field, instr[31:26], from instruction register.
REQ-005 funct  input  6  instruction funct field, instr[5:0].
REQ-006 zero  input  1  ALU zero flag.
REQ-007 mem_ready  input  1  memory access completes in the current cycle.
REQ-008 pcen  output  1  PC register load enable.
REQ-009 irwrite  output  1  instruction register load enable.
REQ-010 regwrite, memwrite, iord, memtoreg, regdst, alusrca  output  1 each  datapath strobes and mux selects.
REQ-011 alusrcb  output  2  ALU B select: 00 reg, 01 const 4, 10 signimm, 11 signimm<<2.
REQ-012 pcsrc  output  2  PC source: 00 ALU result, 01 ALUOut, 10 jump target.
REQ-013 alucontrol  output  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-014 state_o  output  4  current state encoding, for debug.
REQ-015 err  output  1  sticky flag: illegal opcode or memory timeout.

Function
REQ-016 States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BEQ=8, ADDIEX=9, ADDIWB=10, JUMP=11, BNE=12; encodings 13-15 are unused and return to FETCH.
REQ-017 FETCH holds until mem_ready=1, then goes to DECODE.
- While holding: iord=0, alusrca=0, alusrcb=01, alucontrol=add, pcsrc=00.
- irwrite=1 and pcen=1 only in the cycle with mem_ready=1 (Mealy on mem_ready).
REQ-018 DECODE drives alusrca=0, alusrcb=11, alucontrol=add.
- Next state: op 100011/101011 -> MEMADR; 000000 -> EXECUTE; 000100 -> BEQ; 001000 -> ADDIEX; 000010 -> JUMP.
- Any other opcode -> FETCH, and err is set.
REQ-019 MEMADR (alusrca=1, alusrcb=10, add) -> MEMRD for lw, MEMWR for sw.
REQ-020 MEMRD (iord=1) holds until mem_ready, then -> MEMWB.
REQ-021 MEMWB (regdst=0, memtoreg=1, regwrite=1) -> FETCH.
REQ-022 MEMWR (iord=1) asserts memwrite=1 in every waiting cycle and -> FETCH on mem_ready.
REQ-023 EXECUTE (alusrca=1, alusrcb=00, alucontrol from funct) -> ALUWB.
- funct decode: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt; any other funct -> add.
REQ-024 ALUWB (regdst=1, memtoreg=0, regwrite=1) -> FETCH.
REQ-025 BEQ (alusrca=1, alusrcb=00, sub, pcsrc=01) sets pcen=zero, then -> FETCH.
REQ-026 ADDIEX (alusrca=1, alusrcb=10, add) -> ADDIWB.
- ADDIWB (regdst=0, memtoreg=0, regwrite=1) -> FETCH.
REQ-027 JUMP (pcsrc=10, pcen=1) -> FETCH.
REQ-028 Every strobe not listed for a state is 0; every select not listed is 0.
REQ-029 Wait counter rules:
- Clears on entry to FETCH, MEMRD and MEMWR, and increments each waiting cycle.
- When it reaches WAIT_LIMIT without mem_ready: err is set, no write or load strobe fires that cycle, and the next state is FETCH.
- mem_ready=1 in the same cycle as the limit counts as success.
REQ-030 err is never cleared except by reset.

Reset
REQ-031 When reset=1 at a clock edge: state=FETCH, wait counter=0, err=0.
REQ-032 While reset=1: all strobes and pcen are forced to 0, even if mem_ready=1; reset mid-instruction aborts it with no write.

Configuration
REQ-033 With MIPS_MC_BNE_EN defined:
- Opcode 000101 goes from DECODE to BNE.
- BNE drives alusrca=1, alusrcb=00, sub, pcsrc=01, sets pcen=~zero, then -> FETCH.
REQ-034 Without MIPS_MC_BNE_EN: opcode 000101 is illegal per REQ-018, and the BNE state does not exist.

Structure
REQ-035 Package mips_mc_pkg holds the state enum, opcode constants, funct constants and alucontrol constants.
REQ-036 Sub-module mips_mc_aludec, purely combinational (aluop, funct -> alucontrol), is instantiated once.

Verification
REQ-037 reset, then lw op=100011 with mem_ready=1 every cycle -> state sequence 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in state 4.
REQ-038 R-type op=000000, funct=100010 -> alucontrol=110 in EXECUTE; regwrite=1 and regdst=1 in ALUWB.
REQ-039 beq with zero=1 -> pcen=1 in BEQ; with zero=0 -> pcen=0.
REQ-040 FETCH with mem_ready=0 held for 15 cycles -> err=1, irwrite never pulses, state returns to 0.
REQ-041 op=111111 -> DECODE goes to FETCH, err=1; a following reset clears err=0.
REQ-042 reset asserted during MEMWR with mem_ready=1 -> memwrite=0 and state=0 after the edge.

Source files
------------

// File: rtl/mips_mc_pkg.sv
// mips_mc_pkg: shared state, opcode, funct and ALU encodings for the multicycle MIPS controller.
// The BNE state exists only when MIPS_MC_BNE_EN is defined.
package mips_mc_pkg;
  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BEQ     = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
`ifdef MIPS_MC_BNE_EN
    , BNE   = 4'd12
`endif
  } state_t;
  typedef enum logic [1:0] {ALUOP_ADD = 2'd0, ALUOP_SUB = 2'd1, ALUOP_FUNCT = 2'd2} aluop_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] F_ADD    = 6'b100000;
  localparam logic [5:0] F_SUB    = 6'b100010;
  localparam logic [5:0] F_AND    = 6'b100100;
  localparam logic [5:0] F_OR     = 6'b100101;
  localparam logic [5:0] F_SLT    = 6'b101010;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_SLT  = 3'b111;
endpackage

// File: rtl/mips_mc_ctrl_if.sv
// mips_mc_ctrl_if: decode inputs and datapath control outputs between controller and datapath.
interface mips_mc_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pcen;
  logic       irwrite;
  logic       regwrite;
  logic       memwrite;
  logic       iord;
  logic       memtoreg;
  logic       regdst;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state_o;
  logic       err;
  modport slave (
    input  op, funct, zero, mem_ready,
    output pcen, irwrite, regwrite, memwrite, iord, memtoreg, regdst, alusrca,
    output alusrcb, pcsrc, alucontrol, state_o, err
  );
  modport master (
    output op, funct, zero, mem_ready,
    input  pcen, irwrite, regwrite, memwrite, iord, memtoreg, regdst, alusrca,
    input  alusrcb, pcsrc, alucontrol, state_o, err
  );
endinterface

// File: rtl/mips_mc_aludec.sv
// mips_mc_aludec: combinational ALU decoder; unknown funct codes fall back to add.
module mips_mc_aludec
  import mips_mc_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);
  always_comb
    alucontrol = aluop == ALUOP_ADD ? ALU_ADD :
                 aluop == ALUOP_SUB ? ALU_SUB :
                 funct == F_SUB     ? ALU_SUB :
                 funct == F_AND     ? ALU_AND :
                 funct == F_OR      ? ALU_OR  :
                 funct == F_SLT     ? ALU_SLT : ALU_ADD;
endmodule

// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl: multicycle MIPS controller FSM with memory-wait timeout and sticky error flag.
// Define MIPS_MC_BNE_EN to add the bne instruction.
module mips_mc_ctrl
  import mips_mc_pkg::*;
#(
  parameter int WAIT_LIMIT = 15
) (
  input logic          clk,
  input logic          reset,
  mips_mc_ctrl_if.slave bus
);
  localparam int CW = $clog2(WAIT_LIMIT + 1);
  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic          err_q, waiting, timeout, illegal;
  aluop_t        aluop;
  assign waiting = state inside {FETCH, MEMRD, MEMWR};
  // the cycle whose increment would reach the limit is the last one allowed to wait
  assign timeout = waiting && !bus.mem_ready && (int'(cnt) + 1 == WAIT_LIMIT);
  assign bus.state_o = state;
  assign bus.err     = err_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= (waiting && !bus.mem_ready && !timeout) ? cnt + 1'b1 : '0;
      err_q <= err_q | illegal | timeout;
    end
  end
  always_comb begin
    state_n = FETCH;
    illegal = 1'b0;
    case (state)
      FETCH:   state_n = bus.mem_ready ? DECODE : FETCH;
      DECODE:
        case (bus.op)
          OP_LW, OP_SW: state_n = MEMADR;
          OP_RTYPE:     state_n = EXECUTE;
          OP_BEQ:       state_n = BEQ;
          OP_ADDI:      state_n = ADDIEX;
          OP_J:         state_n = JUMP;
`ifdef MIPS_MC_BNE_EN
          OP_BNE:       state_n = BNE;
`endif
          default:      illegal = 1'b1;
        endcase
      MEMADR:  state_n = bus.op == OP_SW ? MEMWR : MEMRD;
      MEMRD:   state_n = bus.mem_ready ? MEMWB : timeout ? FETCH : MEMRD;
      MEMWR:   state_n = (bus.mem_ready || timeout) ? FETCH : MEMWR;
      EXECUTE: state_n = ALUWB;
      ADDIEX:  state_n = ADDIWB;
      default: state_n = FETCH;
    endcase
  end
  always_comb begin
    bus.pcen     = 1'b0;
    bus.irwrite  = 1'b0;
    bus.regwrite = 1'b0;
    bus.memwrite = 1'b0;
    bus.iord     = 1'b0;
    bus.memtoreg = 1'b0;
    bus.regdst   = 1'b0;
    bus.alusrca  = 1'b0;
    bus.alusrcb  = 2'b00;
    bus.pcsrc    = 2'b00;
    aluop        = ALUOP_ADD;
    case (state)
      FETCH: begin
        bus.alusrcb = 2'b01;
        bus.irwrite = bus.mem_ready;
        bus.pcen    = bus.mem_ready;
      end
      DECODE:  bus.alusrcb = 2'b11;
      MEMADR: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
      end
      MEMRD:   bus.iord = 1'b1;
      MEMWB: begin
        bus.memtoreg = 1'b1;
        bus.regwrite = 1'b1;
      end
      MEMWR: begin
        bus.iord     = 1'b1;
        bus.memwrite = !timeout;
      end
      EXECUTE: begin
        bus.alusrca = 1'b1;
        aluop       = ALUOP_FUNCT;
      end
      ALUWB: begin
        bus.regdst   = 1'b1;
        bus.regwrite = 1'b1;
      end
      BEQ: begin
        bus.alusrca = 1'b1;
        bus.pcsrc   = 2'b01;
        bus.pcen    = bus.zero;
        aluop       = ALUOP_SUB;
      end
`ifdef MIPS_MC_BNE_EN
      BNE: begin
        bus.alusrca = 1'b1;
        bus.pcsrc   = 2'b01;
        bus.pcen    = !bus.zero;
        aluop       = ALUOP_SUB;
      end
`endif
      ADDIEX: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
      end
      ADDIWB:  bus.regwrite = 1'b1;
      JUMP: begin
        bus.pcsrc = 2'b10;
        bus.pcen  = 1'b1;
      end
      default: ;
    endcase
    // reset must suppress every write even mid-instruction
    if (reset) begin
      bus.pcen     = 1'b0;
      bus.irwrite  = 1'b0;
      bus.regwrite = 1'b0;
      bus.memwrite = 1'b0;
    end
  end
  mips_mc_aludec u_aludec (
    .aluop      (aluop),
    .funct      (bus.funct),
    .alucontrol (bus.alucontrol)
  );
endmodule

// File: tb/tb_mips_mc_ctrl.sv
// tb_mips_mc_ctrl: directed self-checking bench for the multicycle MIPS controller.
module tb_mips_mc_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int passed = 0;
  mips_mc_ctrl_if bus();
  mips_mc_ctrl #(.WAIT_LIMIT(15)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic test_reset();
    reset = 1'b1; bus.mem_ready = 1'b1; bus.op = 6'b100011; bus.funct = 6'd0; bus.zero = 1'b0;
    tick(); tick();
    checks++; if (bus.state_o !== 4'd0) $display("FAIL rst_state got %0d exp 0", bus.state_o); else passed++;
    checks++; if (bus.err !== 1'b0) $display("FAIL rst_err got %b exp 0", bus.err); else passed++;
    checks++; if (bus.irwrite !== 1'b0) $display("FAIL rst_irwrite got %b exp 0", bus.irwrite); else passed++;
    checks++; if (bus.pcen !== 1'b0) $display("FAIL rst_pcen got %b exp 0", bus.pcen); else passed++;
    reset = 1'b0; #1;
    checks++; if (bus.irwrite !== 1'b1) $display("FAIL fetch_irwrite got %b exp 1", bus.irwrite); else passed++;
    checks++; if (bus.alusrcb !== 2'b01) $display("FAIL fetch_alusrcb got %b exp 01", bus.alusrcb); else passed++;
  endtask
  task automatic test_lw();
    int st[6] = '{0, 1, 2, 3, 4, 0};
    bus.op = 6'b100011; bus.mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      checks++; if (bus.state_o !== 4'(st[i])) $display("FAIL lw_state[%0d] got %0d exp %0d", i, bus.state_o, st[i]); else passed++;
      checks++; if (bus.regwrite !== logic'(st[i] == 4)) $display("FAIL lw_regwrite[%0d] got %b", i, bus.regwrite); else passed++;
      checks++; if (bus.memtoreg !== logic'(st[i] == 4)) $display("FAIL lw_memtoreg[%0d] got %b", i, bus.memtoreg); else passed++;
      if (i < 5) tick();
    end
  endtask
  task automatic test_rtype();
    logic [5:0] fn[6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000111};
    logic [2:0] ac[6] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b010};
    bus.op = 6'b000000; bus.mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.funct = fn[i];
      tick(); tick();
      checks++; if (bus.state_o !== 4'd6) $display("FAIL rt_exec_state[%0d] got %0d exp 6", i, bus.state_o); else passed++;
      checks++; if (bus.alucontrol !== ac[i]) $display("FAIL rt_alucontrol[%0d] got %b exp %b", i, bus.alucontrol, ac[i]); else passed++;
      tick();
      checks++; if ({bus.regwrite, bus.regdst, bus.memtoreg} !== 3'b110) $display("FAIL rt_aluwb[%0d] got %b exp 110", i, {bus.regwrite, bus.regdst, bus.memtoreg}); else passed++;
      tick();
      checks++; if (bus.state_o !== 4'd0) $display("FAIL rt_back_state[%0d] got %0d exp 0", i, bus.state_o); else passed++;
    end
  endtask
  task automatic test_beq();
    logic zv[2] = '{1'b1, 1'b0};
    bus.op = 6'b000100; bus.mem_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.zero = zv[i];
      tick(); tick();
      checks++; if (bus.state_o !== 4'd8) $display("FAIL beq_state got %0d exp 8", bus.state_o); else passed++;
      checks++; if (bus.pcen !== zv[i]) $display("FAIL beq_pcen got %b exp %b", bus.pcen, zv[i]); else passed++;
      checks++; if ({bus.pcsrc, bus.alucontrol} !== 5'b01110) $display("FAIL beq_sel got %b exp 01110", {bus.pcsrc, bus.alucontrol}); else passed++;
      tick();
    end
    bus.zero = 1'b0;
  endtask
  task automatic test_addi_jump();
    bus.op = 6'b001000; bus.mem_ready = 1'b1;
    tick(); tick();
    checks++; if ({bus.state_o, bus.alusrca, bus.alusrcb} !== 7'b1001_1_10) $display("FAIL addiex got %b exp 1001110", {bus.state_o, bus.alusrca, bus.alusrcb}); else passed++;
    tick();
    checks++; if ({bus.state_o, bus.regwrite, bus.regdst} !== 6'b1010_1_0) $display("FAIL addiwb got %b exp 101010", {bus.state_o, bus.regwrite, bus.regdst}); else passed++;
    tick();
    bus.op = 6'b000010;
    tick(); tick();
    checks++; if ({bus.state_o, bus.pcen, bus.pcsrc} !== 7'b1011_1_10) $display("FAIL jump got %b exp 1011110", {bus.state_o, bus.pcen, bus.pcsrc}); else passed++;
    tick();
    checks++; if (bus.state_o !== 4'd0) $display("FAIL jump_back got %0d exp 0", bus.state_o); else passed++;
  endtask
  task automatic test_sw();
    bus.op = 6'b101011; bus.mem_ready = 1'b1;
    tick(); tick();
    checks++; if ({bus.state_o, bus.alusrca, bus.alusrcb} !== 7'b0010_1_10) $display("FAIL sw_memadr got %b exp 0010110", {bus.state_o, bus.alusrca, bus.alusrcb}); else passed++;
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if ({bus.state_o, bus.memwrite, bus.iord} !== 6'b0101_1_1) $display("FAIL sw_wait[%0d] got %b exp 010111", i, {bus.state_o, bus.memwrite, bus.iord}); else passed++;
    end
    bus.mem_ready = 1'b1; #1;
    checks++; if (bus.memwrite !== 1'b1) $display("FAIL sw_ready_memwrite got %b exp 1", bus.memwrite); else passed++;
    tick();
    checks++; if ({bus.state_o, bus.err} !== 5'b0000_0) $display("FAIL sw_done got %b exp 00000", {bus.state_o, bus.err}); else passed++;
  endtask
  task automatic test_limit_success();
    bus.op = 6'b100011; bus.mem_ready = 1'b1;
    tick(); tick();
    bus.mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 14; i++) tick();
    checks++; if ({bus.state_o, bus.err} !== 5'b0011_0) $display("FAIL limit_hold got %b exp 00110", {bus.state_o, bus.err}); else passed++;
    bus.mem_ready = 1'b1;
    tick();
    checks++; if ({bus.state_o, bus.err} !== 5'b0100_0) $display("FAIL limit_success got %b exp 01000", {bus.state_o, bus.err}); else passed++;
    tick();
  endtask
  task automatic test_illegal();
    bus.op = 6'b111111; bus.mem_ready = 1'b1;
    tick();
    checks++; if ({bus.state_o, bus.err} !== 5'b0001_0) $display("FAIL ill_decode got %b exp 00010", {bus.state_o, bus.err}); else passed++;
    tick();
    checks++; if ({bus.state_o, bus.err} !== 5'b0000_1) $display("FAIL ill_err got %b exp 00001", {bus.state_o, bus.err}); else passed++;
    tick(); tick();
    checks++; if (bus.err !== 1'b1) $display("FAIL ill_sticky got %b exp 1", bus.err); else passed++;
    reset = 1'b1;
    tick();
    checks++; if ({bus.state_o, bus.err} !== 5'b0000_0) $display("FAIL ill_reset got %b exp 00000", {bus.state_o, bus.err}); else passed++;
    reset = 1'b0;
  endtask
  task automatic test_bne();
    bus.op = 6'b000101; bus.mem_ready = 1'b1; bus.zero = 1'b0;
    tick(); tick();
`ifdef MIPS_MC_BNE_EN
    checks++; if ({bus.state_o, bus.pcen, bus.pcsrc} !== 7'b1100_1_01) $display("FAIL bne got %b exp 1100101", {bus.state_o, bus.pcen, bus.pcsrc}); else passed++;
`else
    checks++; if ({bus.state_o, bus.err} !== 5'b0000_1) $display("FAIL bne_illegal got %b exp 00001", {bus.state_o, bus.err}); else passed++;
`endif
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask
  task automatic test_fetch_timeout();
    logic pulsed = 1'b0;
    bus.op = 6'b100011; bus.mem_ready = 1'b0; #1;
    for (int i = 0; i < 14; i++) begin
      pulsed |= bus.irwrite;
      tick();
    end
    checks++; if ({bus.state_o, bus.err} !== 5'b0000_0) $display("FAIL fto_before got %b exp 00000", {bus.state_o, bus.err}); else passed++;
    pulsed |= bus.irwrite;
    tick();
    checks++; if ({bus.state_o, bus.err} !== 5'b0000_1) $display("FAIL fto_after got %b exp 00001", {bus.state_o, bus.err}); else passed++;
    checks++; if (pulsed !== 1'b0) $display("FAIL fto_irwrite got %b exp 0", pulsed); else passed++;
  endtask
  task automatic test_memwr_timeout();
    logic allw = 1'b1;
    bus.op = 6'b101011; bus.mem_ready = 1'b1;
    tick(); tick();
    bus.mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 14; i++) begin
      allw &= bus.memwrite;
      tick();
    end
    checks++; if (allw !== 1'b1) $display("FAIL wto_wait_memwrite got %b exp 1", allw); else passed++;
    checks++; if ({bus.state_o, bus.memwrite} !== 5'b0101_0) $display("FAIL wto_limit got %b exp 01010", {bus.state_o, bus.memwrite}); else passed++;
    tick();
    checks++; if (bus.state_o !== 4'd0) $display("FAIL wto_back got %0d exp 0", bus.state_o); else passed++;
  endtask
  task automatic test_reset_mid();
    bus.op = 6'b101011; bus.mem_ready = 1'b1;
    tick(); tick(); tick();
    checks++; if ({bus.state_o, bus.memwrite} !== 5'b0101_1) $display("FAIL mid_memwr got %b exp 01011", {bus.state_o, bus.memwrite}); else passed++;
    reset = 1'b1; #1;
    checks++; if (bus.memwrite !== 1'b0) $display("FAIL mid_memwrite got %b exp 0", bus.memwrite); else passed++;
    tick();
    checks++; if ({bus.state_o, bus.err} !== 5'b0000_0) $display("FAIL mid_state got %b exp 00000", {bus.state_o, bus.err}); else passed++;
    reset = 1'b0;
  endtask
  initial begin
    test_reset();
    test_lw();
    test_rtype();
    test_beq();
    test_addi_jump();
    test_sw();
    test_limit_success();
    test_illegal();
    test_bne();
    test_fetch_timeout();
    test_memwr_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
  initial begin
    #50000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
